pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage core; the generalised successor of the fixed EX/MEM latch.
- Carries a packed payload plus a valid bit between two stages.
- Implements flush, bubble-insertion and hold from the shared stall vector.
- Carries multi-cycle side state (e.g. HI/LO accumulator and cycle count) back to the producing stage during stalls.
- Adds saturating stall, bubble and flush event counters for performance monitoring.

Parameters:
DATA_W, 160, payload width in bits (packed stage fields)
SIDE_W, 66, multi-cycle side-state width (64-bit hilo + 2-bit cnt)
STALL_W, 6, width of the stall vector
STAGE, 3, index of this register's upstream stage in the stall vector; STAGE+1 is downstream; legal range 0..STALL_W-2
BUBBLE_VAL, 0, payload value driven on bubble/flush/reset (encodes NOP opcode, write-disables, zero addresses)
CNT_W, 16, event counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
stall  in  STALL_W  stall vector from control unit, bit=1 means stop
flush  in  1  exception flush from control unit
in_valid  in  1  upstream stage holds a real instruction
in_data  in  DATA_W  upstream payload
in_side  in  SIDE_W  side state produced upstream this cycle
cnt_clr  in  1  synchronous clear of all event counters
out_valid  out  1  registered valid to downstream
out_data  out  DATA_W  registered payload to downstream
out_side  out  SIDE_W  registered side state fed back upstream
stall_cycles  out  CNT_W  count of hold cycles
bubble_cycles  out  CNT_W  count of bubble insertions
flush_count  out  CNT_W  count of flush cycles

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - out_valid=0, out_data=BUBBLE_VAL, out_side=0.
  - All counters = 0.
  - Deasserting reset mid-operation resumes from this empty state.
- One-cycle latency. At each rising edge, the first matching case applies, in this priority:
  1. FLUSH (flush=1):
     - out_valid=0, out_data=BUBBLE_VAL, out_side=0.
     - flush_count++.
     - Flush overrides any stall combination.
  2. BUBBLE (stall[STAGE]=1 and stall[STAGE+1]=0):
     - out_valid=0, out_data=BUBBLE_VAL, out_side=in_side.
     - bubble_cycles++.
  3. ADVANCE (stall[STAGE]=0):
     - out_valid=in_valid, out_data=in_data, out_side=0.
     - in_valid=0 still loads in_data unchanged; downstream qualifies with out_valid.
  4. HOLD (stall[STAGE]=1 and stall[STAGE+1]=1):
     - out_valid and out_data keep their values.
     - out_side=in_side.
     - stall_cycles++.
- Legality of stall patterns:
  - stall[STAGE]=0 with stall[STAGE+1]=1 is illegal from the control unit; it is treated as ADVANCE.
  - A bench assertion flags the pattern.
- Side state:
  - It is captured every cycle the upstream stage is stopped (BUBBLE or HOLD), so a multi-cycle operation resumes from it.
  - It is zeroed when the instruction leaves (ADVANCE) or is killed (FLUSH).
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr zeroes all three on the next edge.
  - cnt_clr has priority over an increment in the same cycle.
  - Counters are not affected by flush except flush_count.
- All outputs come directly from flops; there is no combinational path from input to output.

Decomposition:
- Shared core package holds:
  - stall-vector index constants (STAGE_IF..STAGE_WB);
  - Stop/NoStop encodings;
  - packed payload typedefs per stage boundary (ex_mem_t etc.) with their bubble constants.
  - Instantiations pass $bits(ex_mem_t) as DATA_W and the bubble constant as BUBBLE_VAL.
- One sub-module is natural: sat_counter (CNT_W-wide, inc, clr, saturate), instantiated three times.
- The stage control decode (flush / bubble / advance / hold) stays inline.

Test Plan:
- Reset: rst low while stall=0, in_valid=1, in_data=0xA5.. -> out_valid=0, out_data=BUBBLE_VAL, counters 0 immediately, without waiting for a clock edge.
- Advance: stall=6'b000000, in_valid=1, in_data=X, in_side=0x3 -> next edge out_valid=1, out_data=X, out_side=0.
- Bubble then hold, with STAGE=3:
  - stall=6'b001111 with in_side=0x2_DEADBEEF_00000001 -> out_valid=0, out_data=BUBBLE_VAL, out_side=that in_side, bubble_cycles=1.
  - Then stall=6'b011111 for 3 cycles -> out_data unchanged, out_side tracks in_side, stall_cycles=3.
- Flush priority: flush=1 with stall=6'b011111 -> out_valid=0, out_data=BUBBLE_VAL, out_side=0, flush_count=1, stall_cycles unchanged.
- Saturation/clear:
  - CNT_W=4, 20 hold cycles -> stall_cycles=15.
  - cnt_clr=1 together with a hold cycle -> stall_cycles=0 next edge.
- Illegal pattern: stall[3]=0, stall[4]=1 -> behaves as advance; the bench assertion fires.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared core package: stall-vector layout, stop encodings, stage
// boundary payload types with their bubble constants, and the stage
// register control decode type.
package pipe_stage_reg_pkg;

  // Bit positions of each stage in the control unit's stall vector
  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  // Stall vector bit values
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Payload crossing the IF/ID boundary
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '0;

  // Payload crossing the EX/MEM boundary (160 bits)
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  aluop;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        whilo;
    logic [15:0] excepttype;
    logic        is_in_delayslot;
  } ex_mem_t;

  // NOP opcode, write enables off, zero addresses
  localparam ex_mem_t EX_MEM_BUBBLE = '0;

  // What the stage register does at the next edge
  typedef enum logic [1:0] {
    OP_ADVANCE,
    OP_BUBBLE,
    OP_HOLD,
    OP_FLUSH
  } stage_op_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload plus valid, flush / bubble /
// hold handling from the stall vector, side state fed back upstream
// while stopped, and saturating event counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W     = 160,
  parameter int                SIDE_W     = 66,
  parameter int                STALL_W    = 6,
  parameter int                STAGE      = STAGE_EX,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SIDE_W-1:0]  in_side,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [SIDE_W-1:0]  out_side,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   bubble_cycles,
  output logic [CNT_W-1:0]   flush_count
);

  logic      up_stop;
  logic      down_stop;
  logic      unused_stall;
  stage_op_e op;

  assign up_stop      = (stall[STAGE] == STOP);
  assign down_stop    = (stall[STAGE+1] == STOP);
  assign unused_stall = ^stall;

  // Decode the edge action; upstream running with downstream stopped is illegal and falls through to advance
  always_comb begin
    op = OP_ADVANCE;
    if (flush) begin
      op = OP_FLUSH;
    end else if (up_stop && !down_stop) begin
      op = OP_BUBBLE;
    end else if (up_stop && down_stop) begin
      op = OP_HOLD;
    end
  end

  // Stage register: side state is captured while upstream is stopped and cleared once the instruction leaves or dies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE_VAL;
      out_side  <= '0;
    end else begin
      case (op)
        OP_FLUSH: begin
          out_valid <= 1'b0;
          out_data  <= BUBBLE_VAL;
          out_side  <= '0;
        end
        OP_BUBBLE: begin
          out_valid <= 1'b0;
          out_data  <= BUBBLE_VAL;
          out_side  <= in_side;
        end
        OP_HOLD: begin
          out_side  <= in_side;
        end
        default: begin
          out_valid <= in_valid;
          out_data  <= in_data;
          out_side  <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (op == OP_HOLD),
    .clr   (cnt_clr),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (op == OP_BUBBLE),
    .clr   (cnt_clr),
    .count (bubble_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (op == OP_FLUSH),
    .clr   (cnt_clr),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (EX/MEM payload, 4-bit counters).
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW   = $bits(ex_mem_t);
  localparam int SW   = 66;
  localparam int STW  = 6;
  localparam int STG  = 3;
  localparam int CW   = 4;
  localparam int MAXC = 15;
  localparam logic [DW-1:0] BUB = 160'h0000_0F00_0000_0000_0000_0000_0000_0000_0000_00A5;

  logic           clk = 1'b0;
  logic           rst;
  logic [STW-1:0] stall;
  logic           flush;
  logic           in_valid;
  logic [DW-1:0]  in_data;
  logic [SW-1:0]  in_side;
  logic           cnt_clr;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [SW-1:0]  out_side;
  logic [CW-1:0]  stall_cycles;
  logic [CW-1:0]  bubble_cycles;
  logic [CW-1:0]  flush_count;

  logic           m_valid;
  logic [DW-1:0]  m_data;
  logic [SW-1:0]  m_side;
  int             m_stall;
  int             m_bubble;
  int             m_flush;

  int checks = 0;
  int errors = 0;
  int illegal_seen = 0;

  pipe_stage_reg #(
    .DATA_W(DW), .SIDE_W(SW), .STALL_W(STW), .STAGE(STG),
    .BUBBLE_VAL(BUB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_side(in_side),
    .cnt_clr(cnt_clr), .out_valid(out_valid), .out_data(out_data),
    .out_side(out_side), .stall_cycles(stall_cycles),
    .bubble_cycles(bubble_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Illegal stall pattern monitor: upstream running while downstream is stopped
  always @(negedge clk) begin
    if (rst === 1'b1 && stall[STG] === 1'b0 && stall[STG+1] === 1'b1) begin
      illegal_seen++;
      $display("[TB] note: illegal stall pattern %b seen at %0t", stall, $time);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [SW-1:0] rand_side();
    logic [1:0] c;
    c = 2'($urandom_range(0, 3));
    return {c, $urandom, $urandom};
  endfunction

  function automatic int sat_inc(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = BUB; m_side = '0;
    m_stall = 0; m_bubble = 0; m_flush = 0;
  endtask

  // Reference behaviour at one rising edge, from the priority rules
  task automatic model_edge();
    bit up, down;
    up = stall[STG]; down = stall[STG+1];
    if (flush) begin
      m_valid = 1'b0; m_data = BUB; m_side = '0; m_flush = sat_inc(m_flush);
    end else if (up && !down) begin
      m_valid = 1'b0; m_data = BUB; m_side = in_side; m_bubble = sat_inc(m_bubble);
    end else if (!up) begin
      m_valid = in_valid; m_data = in_data; m_side = '0;
    end else begin
      m_side = in_side; m_stall = sat_inc(m_stall);
    end
    if (cnt_clr) begin
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end
  endtask

  task automatic drive(input logic f, input logic [STW-1:0] st, input logic v,
                       input logic [DW-1:0] d, input logic [SW-1:0] s, input logic c);
    flush = f; stall = st; in_valid = v; in_data = d; in_side = s; cnt_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    d = {5{32'hA5A5A5A5}};
    rst = 1'b0;
    drive(0, '0, 1, d, '0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid got %b want 1", out_valid); end
    drive(0, 6'b011111, 1, d, 66'h1, 0);
    tick();
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("[TB] FAIL pre_reset_stall got %0d want 1", stall_cycles); end
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== BUB) begin errors++; $display("[TB] FAIL reset_data got %h want %h", out_data, BUB); end
    checks++; if (out_side !== '0) begin errors++; $display("[TB] FAIL reset_side got %h want 0", out_side); end
    checks++; if ({stall_cycles, bubble_cycles, flush_count} !== '0) begin errors++;
      $display("[TB] FAIL reset_counters got %0d/%0d/%0d want 0/0/0", stall_cycles, bubble_cycles, flush_count); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_advance();
    logic [DW-1:0] x;
    x = rand_data();
    drive(0, 6'b000000, 1, x, 66'h3, 1);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL adv_valid got %b want 1", out_valid); end
    checks++; if (out_data !== x) begin errors++; $display("[TB] FAIL adv_data got %h want %h", out_data, x); end
    checks++; if (out_side !== '0) begin errors++; $display("[TB] FAIL adv_side got %h want 0", out_side); end
    x = rand_data();
    drive(0, 6'b000000, 0, x, 66'h1, 0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL adv_inval_valid got %b want 0", out_valid); end
    checks++; if (out_data !== x) begin errors++; $display("[TB] FAIL adv_inval_data got %h want %h", out_data, x); end
  endtask

  task automatic test_bubble_hold();
    logic [SW-1:0] s;
    drive(0, 6'b001111, 1, rand_data(), 66'h2_DEADBEEF_00000001, 0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bub_valid got %b want 0", out_valid); end
    checks++; if (out_data !== BUB) begin errors++; $display("[TB] FAIL bub_data got %h want %h", out_data, BUB); end
    checks++; if (out_side !== 66'h2_DEADBEEF_00000001) begin errors++; $display("[TB] FAIL bub_side got %h want 2deadbeef00000001", out_side); end
    checks++; if (bubble_cycles !== 4'd1) begin errors++; $display("[TB] FAIL bub_count got %0d want 1", bubble_cycles); end
    for (int i = 0; i < 3; i++) begin
      s = rand_side();
      drive(0, 6'b011111, 1, rand_data(), s, 0);
      tick();
      checks++; if (out_data !== BUB) begin errors++; $display("[TB] FAIL hold_data got %h want %h", out_data, BUB); end
      checks++; if (out_side !== s) begin errors++; $display("[TB] FAIL hold_side got %h want %h", out_side, s); end
    end
    checks++; if (stall_cycles !== 4'd3) begin errors++; $display("[TB] FAIL hold_count got %0d want 3", stall_cycles); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] y;
    logic [SW-1:0] s;
    y = rand_data(); s = rand_side();
    drive(0, 6'b000000, 1, y, '0, 1);
    tick();
    drive(0, 6'b011111, 0, rand_data(), s, 0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== y) begin errors++; $display("[TB] FAIL hold_keep got %b/%h want 1/%h", out_valid, out_data, y); end
    checks++; if (out_side !== s) begin errors++; $display("[TB] FAIL hold_side2 got %h want %h", out_side, s); end
    drive(1, 6'b011111, 1, rand_data(), rand_side(), 0);
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== BUB || out_side !== '0) begin errors++;
      $display("[TB] FAIL flush_out got %b/%h/%h want 0/%h/0", out_valid, out_data, out_side, BUB); end
    checks++; if (flush_count !== 4'd1) begin errors++; $display("[TB] FAIL flush_count got %0d want 1", flush_count); end
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("[TB] FAIL flush_stall got %0d want 1", stall_cycles); end
  endtask

  task automatic test_saturation();
    drive(0, 6'b011111, 1, rand_data(), rand_side(), 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 6'b111111, 1, rand_data(), rand_side(), 0);
      tick();
    end
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("[TB] FAIL sat_count got %0d want 15", stall_cycles); end
    drive(0, 6'b011111, 1, rand_data(), rand_side(), 1);
    tick();
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("[TB] FAIL clr_count got %0d want 0", stall_cycles); end
  endtask

  task automatic test_illegal();
    int seen0;
    logic [DW-1:0] z;
    logic [CW-1:0] sc;
    seen0 = illegal_seen; sc = stall_cycles; z = rand_data();
    drive(0, 6'b010000, 1, z, rand_side(), 0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== z || out_side !== '0) begin errors++;
      $display("[TB] FAIL illegal_adv got %b/%h/%h want 1/%h/0", out_valid, out_data, out_side, z); end
    checks++; if (stall_cycles !== sc) begin errors++; $display("[TB] FAIL illegal_stall got %0d want %0d", stall_cycles, sc); end
    checks++; if (illegal_seen <= seen0) begin errors++; $display("[TB] FAIL illegal_flag got %0d want >%0d", illegal_seen, seen0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) == 0), 6'($urandom), 1'($urandom), rand_data(), rand_side(),
            ($urandom_range(0, 15) == 0));
      tick();
      checks++; if (out_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid[%0d] got %b want %b", i, out_valid, m_valid); end
      checks++; if (out_data !== m_data) begin errors++; $display("[TB] FAIL rnd_data[%0d] got %h want %h", i, out_data, m_data); end
      checks++; if (out_side !== m_side) begin errors++; $display("[TB] FAIL rnd_side[%0d] got %h want %h", i, out_side, m_side); end
      checks++; if (int'(stall_cycles) != m_stall) begin errors++; $display("[TB] FAIL rnd_stall[%0d] got %0d want %0d", i, stall_cycles, m_stall); end
      checks++; if (int'(bubble_cycles) != m_bubble) begin errors++; $display("[TB] FAIL rnd_bubble[%0d] got %0d want %0d", i, bubble_cycles, m_bubble); end
      checks++; if (int'(flush_count) != m_flush) begin errors++; $display("[TB] FAIL rnd_flush[%0d] got %0d want %0d", i, flush_count, m_flush); end
    end
  endtask

  initial begin
    drive(0, '0, 0, '0, '0, 0);
    test_reset();
    test_advance();
    test_bubble_hold();
    test_flush();
    test_saturation();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
